// File: rtl/color_bar_checker_if.sv
// color_bar_checker_if
// Pixel-bus bundle between a colour-bar pattern source (master) and the
// colour-bar checker (slave).
//
// Stream semantics: there is no backpressure. One pixel is presented per
// clock. active_video qualifies the pixel, acting as the valid signal, and the
// slave always accepts it. frame_start marks the first pixel of a frame whether
// or not that pixel is active. Result outputs are registered and change only
// on clock edges.
//
// Signals:
//   enable        checker enable (master -> slave)
//   frame_start   first-pixel-of-frame pulse
//   x, y          pixel coordinates (10 / 9 bits)
//   active_video  pixel lies in the active region
//   rgb           pixel colour {B[1:0],G[2:0],R[2:0]}
//   frame_done    one-cycle pulse when the per-frame results update
//   frame_pass    last completed frame stayed within the error threshold
//   frame_errors  mismatch count of the last completed frame (saturating)
//   pixel_count   active pixels checked in the last completed frame
//   first_err_*   coordinates and colour of the first mismatch since enable
//   sticky_fail   some completed frame has failed since enable
//   state         debug view of the checker FSM state
interface color_bar_checker_if;
  logic        enable;
  logic        frame_start;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        active_video;
  logic [7:0]  rgb;

  logic        frame_done;
  logic        frame_pass;
  logic [15:0] frame_errors;
  logic [18:0] pixel_count;
  logic [9:0]  first_err_x;
  logic [8:0]  first_err_y;
  logic [7:0]  first_err_rgb;
  logic        sticky_fail;
  logic [1:0]  state;

  modport master (
    output enable, frame_start, x, y, active_video, rgb,
    input  frame_done, frame_pass, frame_errors, pixel_count,
    input  first_err_x, first_err_y, first_err_rgb, sticky_fail, state
  );

  modport slave (
    input  enable, frame_start, x, y, active_video, rgb,
    output frame_done, frame_pass, frame_errors, pixel_count,
    output first_err_x, first_err_y, first_err_rgb, sticky_fail, state
  );
endinterface

// File: rtl/color_bar_checker.sv
// color_bar_checker
// Receive-side checker for the 8-bar colour pattern. Each active pixel is
// compared against the bar colour implied by its x coordinate (rows above
// START_Y must be black). Errors and checked pixels are accumulated per frame
// and reported with a pass/fail verdict at every frame boundary.
//
// Ports:
//   clk    pixel clock, all state on the rising edge
//   reset  asynchronous, active-high reset; all outputs return to 0
//   bus    color_bar_checker_if.slave: pixel stream in, frame results out
//
// Pipeline: stage 1 registers the pixel bus; stage 2 derives the expected
// colour and mismatch flag from stage 1 and folds them into the counters on
// the following edge. A frame_start captured at edge E0 produces frame_done
// during the cycle after E1.
module color_bar_checker #(
  parameter logic [8:0]  START_Y    = 9'd0,
  parameter logic [9:0]  BAR_WIDTH  = 10'd75,
  parameter logic [15:0] ERR_THRESH = 16'd0
) (
  input  logic               clk,
  input  logic               reset,
  color_bar_checker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t state;

  // Stage 1 registers.
  logic       s1_frame_start;
  logic       s1_active;
  logic [9:0] s1_x;
  logic [8:0] s1_y;
  logic [7:0] s1_rgb;

  // Running counters for the frame in progress.
  logic [15:0] err_cnt;
  logic [18:0] pix_cnt;

  // First-mismatch capture.
  logic       fe_valid;
  logic [9:0] fe_x;
  logic [8:0] fe_y;
  logic [7:0] fe_rgb;

  // Registered results.
  logic        done_q;
  logic        pass_q;
  logic [15:0] errors_q;
  logic [18:0] count_q;
  logic        sticky_q;

  // Stage 2 combinational signals.
  logic [2:0]  bar;
  logic        in_bar_rows;
  logic [7:0]  exp_rgb;
  logic        mismatch;
  logic [15:0] err_inc;
  logic [18:0] pix_inc;
  logic [15:0] err_seed;
  logic [18:0] pix_seed;
  logic        frame_ok;
  logic        capture;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_frame_start <= 1'b0;
      s1_active      <= 1'b0;
      s1_x           <= '0;
      s1_y           <= '0;
      s1_rgb         <= '0;
    end else begin
      s1_frame_start <= bus.frame_start;
      s1_active      <= bus.active_video;
      s1_x           <= bus.x;
      s1_y           <= bus.y;
      s1_rgb         <= bus.rgb;
    end
  end

  // Bar index from a ladder of constant thresholds k*BAR_WIDTH; the last
  // threshold passed wins, which also clamps the index to 7.
  always_comb begin
    bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if ({3'b000, s1_x} >= (13'(k) * {3'b000, BAR_WIDTH})) begin
        bar = 3'(k);
      end
    end
  end

  // y >= START_Y written as y + 1 > START_Y so that START_Y = 0 does not turn
  // into a degenerate unsigned compare against zero.
  assign in_bar_rows = (({1'b0, s1_y} + 10'd1) > {1'b0, START_Y});

  always_comb begin
    exp_rgb = 8'h00;
    if (in_bar_rows) begin
      case (bar)
        3'd0:    exp_rgb = 8'h00;  // black
        3'd1:    exp_rgb = 8'h07;  // red
        3'd2:    exp_rgb = 8'h38;  // green
        3'd3:    exp_rgb = 8'h3F;  // yellow
        3'd4:    exp_rgb = 8'hC0;  // blue
        3'd5:    exp_rgb = 8'hC7;  // magenta
        3'd6:    exp_rgb = 8'hF8;  // cyan
        default: exp_rgb = 8'hFF;  // white
      endcase
    end
  end

  assign mismatch = s1_active && (s1_rgb != exp_rgb);

  // Saturating increments, plus seed values for the pixel that opens a frame.
  assign err_inc  = (err_cnt == 16'hFFFF) ? err_cnt : err_cnt + 16'(mismatch);
  assign pix_inc  = (pix_cnt == 19'h7FFFF) ? pix_cnt : pix_cnt + 19'(s1_active);
  assign err_seed = 16'(mismatch);
  assign pix_seed = 19'(s1_active);
  assign frame_ok = (err_cnt <= ERR_THRESH);

  // A pixel is "checked" in CHECK, and also when it is the frame_start pixel
  // that moves SYNC into CHECK.
  assign capture = mismatch && !fe_valid &&
                   ((state == CHECK) || ((state == SYNC) && s1_frame_start));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      err_cnt  <= '0;
      pix_cnt  <= '0;
      fe_valid <= 1'b0;
      fe_x     <= '0;
      fe_y     <= '0;
      fe_rgb   <= '0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      errors_q <= '0;
      count_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!bus.enable) begin
        // Frame results are held; everything tied to the current run clears.
        state    <= IDLE;
        err_cnt  <= '0;
        pix_cnt  <= '0;
        sticky_q <= 1'b0;
        fe_valid <= 1'b0;
        fe_x     <= '0;
        fe_y     <= '0;
        fe_rgb   <= '0;
      end else begin
        case (state)
          IDLE: begin
            err_cnt <= '0;
            pix_cnt <= '0;
            state   <= SYNC;
          end
          SYNC: begin
            // Anything before the first frame_start is a partial frame.
            if (s1_frame_start) begin
              err_cnt <= err_seed;
              pix_cnt <= pix_seed;
              state   <= CHECK;
            end
          end
          CHECK: begin
            if (s1_frame_start) begin
              // Close the previous frame; the boundary pixel opens the next.
              done_q   <= 1'b1;
              pass_q   <= frame_ok;
              errors_q <= err_cnt;
              count_q  <= pix_cnt;
              if (!frame_ok) begin
                sticky_q <= 1'b1;
              end
              err_cnt <= err_seed;
              pix_cnt <= pix_seed;
            end else begin
              err_cnt <= err_inc;
              pix_cnt <= pix_inc;
            end
          end
          default: state <= IDLE;
        endcase
        if (capture) begin
          fe_valid <= 1'b1;
          fe_x     <= s1_x;
          fe_y     <= s1_y;
          fe_rgb   <= s1_rgb;
        end
      end
    end
  end

  assign bus.frame_done    = done_q;
  assign bus.frame_pass    = pass_q;
  assign bus.frame_errors  = errors_q;
  assign bus.pixel_count   = count_q;
  assign bus.first_err_x   = fe_x;
  assign bus.first_err_y   = fe_y;
  assign bus.first_err_rgb = fe_rgb;
  assign bus.sticky_fail   = sticky_q;
  assign bus.state         = state;

endmodule

// File: tb/tb_color_bar_checker.sv
// tb_color_bar_checker
// Randomized and directed pixel streams for color_bar_checker. A behavioural
// model computes the expected bar colour with division, counts errors and
// pixels per frame, and queues a frame report (with its due cycle) at every
// frame boundary; a negedge monitor matches frame_done pulses to that queue.
module tb_color_bar_checker;
  localparam logic [8:0]  START_Y    = 9'd20;
  localparam logic [9:0]  BAR_WIDTH  = 10'd75;
  localparam logic [15:0] ERR_THRESH = 16'd1;

  logic clk = 1'b0;
  logic reset;

  color_bar_checker_if ifc();

  color_bar_checker #(
    .START_Y    (START_Y),
    .BAR_WIDTH  (BAR_WIDTH),
    .ERR_THRESH (ERR_THRESH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];
  int          due_q[$];

  // Model state
  bit          m_synced = 1'b0;
  int          m_err = 0;
  int          m_pix = 0;
  bit          m_sticky = 1'b0;
  bit          m_fe_valid = 1'b0;
  logic [9:0]  m_fe_x = '0;
  logic [8:0]  m_fe_y = '0;
  logic [7:0]  m_fe_rgb = '0;
  logic [35:0] m_last = '0;  // {pass, errors, pixels} of the last report

  int bx[6] = '{0, 74, 75, 524, 525, 639};
  int by[4] = '{19, 20, 100, 479};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] bar_color(input int xx);
    int b;
    b = xx / int'(BAR_WIDTH);
    if (b > 7) b = 7;
    case (b)
      0:       return 8'h00;
      1:       return 8'h07;
      2:       return 8'h38;
      3:       return 8'h3F;
      4:       return 8'hC0;
      5:       return 8'hC7;
      6:       return 8'hF8;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] ref_color(input int xx, input int yy);
    if (yy < int'(START_Y)) return 8'h00;
    return bar_color(xx);
  endfunction

  // Driver: one call per clock; inputs change on the falling edge.
  task automatic drive(input bit en, input bit fs, input int xx, input int yy,
                       input bit av, input logic [7:0] c);
    bit bad;
    bit pass;
    bit rep_pending;
    @(negedge clk);
    ifc.enable       = en;
    ifc.frame_start  = fs;
    ifc.x            = 10'(xx);
    ifc.y            = 9'(yy);
    ifc.active_video = av;
    ifc.rgb          = c;
    bad = av && (c != ref_color(xx, yy));
    rep_pending = 1'b0;
    if (!en) begin
      m_synced   = 1'b0;
      m_err      = 0;
      m_pix      = 0;
      m_sticky   = 1'b0;
      m_fe_valid = 1'b0;
      m_fe_x     = '0;
      m_fe_y     = '0;
      m_fe_rgb   = '0;
    end else begin
      if (fs && m_synced) begin
        pass        = (m_err <= int'(ERR_THRESH));
        m_sticky    = m_sticky | !pass;
        m_last      = {pass, 16'(m_err), 19'(m_pix)};
        rep_pending = 1'b1;
      end
      if (fs) begin
        m_synced = 1'b1;
        m_err    = 0;
        m_pix    = 0;
      end
      if (m_synced && av) begin
        if (m_pix < 524287) m_pix++;
        if (bad) begin
          if (m_err < 65535) m_err++;
          if (!m_fe_valid) begin
            m_fe_valid = 1'b1;
            m_fe_x     = 10'(xx);
            m_fe_y     = 9'(yy);
            m_fe_rgb   = c;
          end
        end
      end
      if (rep_pending) begin
        exp_q.push_back({m_fe_x, m_fe_y, m_fe_rgb, m_sticky, m_last});
        due_q.push_back(cyc + 2);
      end
    end
  endtask

  // fs_mode: 0 = continue current frame, 1 = start with an active pixel,
  // 2 = start with frame_start on an inactive pixel.
  task automatic rand_frame(input int n, input int pct, input bit top_bars, input int fs_mode);
    for (int i = 0; i < n; i++) begin
      int xx;
      int yy;
      bit av;
      logic [7:0] c;
      xx = int'($urandom_range(0, 639));
      if (top_bars && ($urandom_range(0, 1) == 1)) yy = int'($urandom_range(0, 19));
      else yy = int'($urandom_range(0, 479));
      av = ($urandom_range(0, 9) != 0);
      if (i == 0 && fs_mode == 1) av = 1'b1;
      if (i == 0 && fs_mode == 2) av = 1'b0;
      c = top_bars ? bar_color(xx) : ref_color(xx, yy);
      if (int'($urandom_range(0, 99)) < pct) c = c ^ 8'($urandom_range(1, 255));
      drive(1'b1, (i == 0) && (fs_mode != 0), xx, yy, av, c);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [63:0] rep;
    if (!reset) begin
      if (due_q.size() > 0 && cyc >= due_q[0]) begin
        rep = exp_q.pop_front();
        void'(due_q.pop_front());
        check_eq("frame_done", 64'(ifc.frame_done), 64'd1);
        check_eq("pixel_count", 64'(ifc.pixel_count), 64'(rep[18:0]));
        check_eq("frame_errors", 64'(ifc.frame_errors), 64'(rep[34:19]));
        check_eq("frame_pass", 64'(ifc.frame_pass), 64'(rep[35]));
        check_eq("sticky_fail", 64'(ifc.sticky_fail), 64'(rep[36]));
        check_eq("first_err", 64'({ifc.first_err_x, ifc.first_err_y, ifc.first_err_rgb}),
                 64'(rep[63:37]));
      end else if (ifc.frame_done) begin
        check_eq("frame_done_spurious", 64'(ifc.frame_done), 64'd0);
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_frame"}, 64'({ifc.frame_done, ifc.frame_pass, ifc.frame_errors,
                                   ifc.pixel_count, ifc.sticky_fail}), 64'd0);
    check_eq({tag, "_first_err"}, 64'({ifc.first_err_x, ifc.first_err_y, ifc.first_err_rgb}),
             64'd0);
  endtask

  // Stimulus
  initial begin
    reset            = 1'b1;
    ifc.enable       = 1'b0;
    ifc.frame_start  = 1'b0;
    ifc.x            = '0;
    ifc.y            = '0;
    ifc.active_video = 1'b0;
    ifc.rgb          = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_values");
    reset = 1'b0;

    repeat (3) drive(1'b1, 1'b0, 0, 0, 1'b0, 8'h00);

    // Ideal frames: first one only synchronises.
    rand_frame(200, 0, 1'b0, 1);
    rand_frame(250, 0, 1'b0, 1);

    // Single mismatch at x=160 (green bar) within threshold.
    rand_frame(60, 0, 1'b0, 1);
    drive(1'b1, 1'b0, 160, 30, 1'b1, 8'h07);
    rand_frame(60, 0, 1'b0, 0);
    check_eq("first_err_x_direct", 64'(ifc.first_err_x), 64'(m_fe_x));
    check_eq("first_err_rgb_direct", 64'(ifc.first_err_rgb), 64'(m_fe_rgb));

    // Two mismatches: just over threshold.
    rand_frame(40, 0, 1'b0, 1);
    drive(1'b1, 1'b0, 600, 200, 1'b1, 8'h00);
    drive(1'b1, 1'b0, 0, 5, 1'b1, 8'h07);
    rand_frame(40, 0, 1'b0, 0);

    // Bar boundaries with correct colours, including the row above START_Y.
    drive(1'b1, 1'b1, 0, 0, 1'b1, 8'h00);
    foreach (by[j]) foreach (bx[i]) drive(1'b1, 1'b0, bx[i], by[j], 1'b1, ref_color(bx[i], by[j]));

    // Boundary shifted by one pixel on rows 20..25: one error per row.
    drive(1'b1, 1'b1, 0, 0, 1'b1, 8'h00);
    for (int r = 20; r < 26; r++) begin
      drive(1'b1, 1'b0, 74, r, 1'b1, 8'h00);
      drive(1'b1, 1'b0, 75, r, 1'b1, 8'h00);
      drive(1'b1, 1'b0, 524, r, 1'b1, 8'hF8);
    end

    // Rows above START_Y driven with bars.
    rand_frame(300, 0, 1'b1, 1);

    // Frame boundary on an inactive pixel, then random corruption levels.
    rand_frame(200, 2, 1'b0, 2);
    for (int f = 0; f < 4; f++) rand_frame(int'($urandom_range(100, 300)), f, 1'b0, 1);
    rand_frame(150, 1, 1'b0, 2);

    // Drop enable mid-frame.
    rand_frame(60, 0, 1'b0, 1);
    check_eq("sticky_before_drop", 64'(ifc.sticky_fail), 64'(m_sticky));
    repeat (4) drive(1'b0, 1'b0, 0, 0, 1'b0, 8'h00);
    check_eq("sticky_cleared", 64'(ifc.sticky_fail), 64'd0);
    check_eq("first_err_cleared", 64'({ifc.first_err_x, ifc.first_err_y, ifc.first_err_rgb}),
             64'd0);
    check_eq("hold_pass", 64'(ifc.frame_pass), 64'(m_last[35]));
    check_eq("hold_errors", 64'(ifc.frame_errors), 64'(m_last[34:19]));
    check_eq("hold_pixels", 64'(ifc.pixel_count), 64'(m_last[18:0]));
    repeat (2) drive(1'b1, 1'b0, 0, 0, 1'b0, 8'h00);

    // Re-enabled: first frame only synchronises.
    rand_frame(120, 3, 1'b0, 1);
    rand_frame(200, 1, 1'b0, 1);

    // Every pixel wrong: error counter saturates.
    drive(1'b1, 1'b1, 10, 100, 1'b1, 8'h55);
    for (int i = 0; i < 65600; i++) begin
      int xx;
      int yy;
      xx = int'($urandom_range(0, 639));
      yy = int'($urandom_range(0, 479));
      drive(1'b1, 1'b0, xx, yy, 1'b1, ~ref_color(xx, yy));
    end

    // Next frame reports the saturated one, then reset lands mid-frame.
    rand_frame(30, 5, 1'b0, 1);
    #2 reset = 1'b1;
    #1 check_outputs_zero("async_reset");
    check_eq("pending_reports", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
